// File: rtl/core_launch_controller_if.sv
// rtl/core_launch_controller_if.sv - HPS control-window bus for core_launch_controller
//
// Purpose: groups the register-window signals of the HPS control slave port.
// Ports:
//   address_control   master->slave  register select (8 words)
//   data_in_control   master->slave  write data
//   write_control     master->slave  write strobe, one write per cycle
//   read_control      master->slave  read strobe
//   data_out_control  slave->master  registered read data (1-cycle latency)
interface core_launch_controller_if #(
  parameter int WIDTH = 32
) ();
  logic [2:0]       address_control;
  logic [WIDTH-1:0] data_in_control;
  logic             write_control;
  logic             read_control;
  logic [WIDTH-1:0] data_out_control;

  modport master (
    output address_control, data_in_control, write_control, read_control,
    input  data_out_control
  );

  modport slave (
    input  address_control, data_in_control, write_control, read_control,
    output data_out_control
  );
endinterface

// File: rtl/core_launch_controller.sv
// rtl/core_launch_controller.sv - launch sequencer for the videocard compute cores
//
// Purpose: latches the per-core enables on a start command, pulses core_start,
// holds core_run until every active core has reported done (or the watchdog
// expires), counts run cycles and raises a sticky finish interrupt.
// Ports:
//   clk               single clock
//   reset_sink_reset  synchronous active-high reset
//   ctrl              control register window (slave modport)
//   core_done         per-core done, pulse or level
//   core_start        one-cycle launch pulse per active core
//   core_run          high per active core while the run is in progress
//   irq               finish interrupt, mirrors STATUS bit0
module core_launch_controller #(
  parameter int CORES   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                     clk,
  input  logic                     reset_sink_reset,
  core_launch_controller_if.slave  ctrl,
  input  logic [CORES-1:0]         core_done,
  output logic [CORES-1:0]         core_start,
  output logic [CORES-1:0]         core_run,
  output logic                     irq
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_e;

  state_e           state_q, state_d;
  logic [CORES-1:0] en_q, en_d;
  logic [CORES-1:0] active_q, active_d;
  logic [CORES-1:0] done_seen_q, done_seen_d;
  logic [CORES-1:0] start_q, start_d;
  logic [CORES-1:0] run_q, run_d;
  logic             fin_q, fin_d;
  logic             tmo_q, tmo_d;
  logic [31:0]      cycles_q, cycles_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             start_req;
  logic [CORES-1:0] done_now;
  logic             complete;
  logic             expire;
  logic             unused_wdata;

  assign unused_wdata = ^ctrl.data_in_control[WIDTH-1:1];

  assign start_req = ctrl.write_control && (ctrl.address_control == 3'd0) &&
                     ctrl.data_in_control[0];
  assign done_now  = done_seen_q | (core_done & active_q);
  assign complete  = (done_now == active_q);
  assign expire    = (TIMEOUT != 0) && (cycles_q == 32'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    active_d    = active_q;
    done_seen_d = done_seen_q;
    start_d     = '0;
    run_d       = run_q;
    fin_d       = fin_q;
    tmo_d       = tmo_q;
    cycles_d    = cycles_q;
    rdata_d     = rdata_q;

    if (ctrl.write_control) begin
      for (int i = 0; i < CORES; i++) begin
        if (ctrl.address_control == 3'(i + 2)) en_d[i] = ctrl.data_in_control[0];
      end
      if ((ctrl.address_control == 3'd1) && !ctrl.data_in_control[0]) begin
        fin_d = 1'b0;
        tmo_d = 1'b0;
      end
    end

    // Status sets below come after the software clear so a same-cycle set wins.
    case (state_q)
      IDLE: begin
        if (start_req) begin
          active_d    = en_q;
          done_seen_d = '0;
          cycles_d    = '0;
          start_d     = en_q;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        if (active_q == '0) begin
          fin_d   = 1'b1;
          state_d = FINISH;
        end else begin
          run_d   = active_q;
          state_d = RUN;
        end
      end
      RUN: begin
        cycles_d    = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
        done_seen_d = done_now;
        // Completion is tested first so it beats a watchdog expiry in the same cycle.
        if (complete) begin
          fin_d   = 1'b1;
          run_d   = '0;
          state_d = FINISH;
        end else if (expire) begin
          fin_d   = 1'b1;
          tmo_d   = 1'b1;
          run_d   = '0;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ctrl.read_control) begin
      rdata_d = '0;
      for (int i = 0; i < CORES; i++) begin
        if (ctrl.address_control == 3'(i + 2)) rdata_d = WIDTH'(en_q[i]);
      end
      case (ctrl.address_control)
        3'd0:    rdata_d = WIDTH'(state_q != IDLE);
        3'd1:    rdata_d = WIDTH'({tmo_q, fin_q});
        3'd6:    rdata_d = WIDTH'(cycles_q);
        3'd7:    rdata_d = WIDTH'(done_seen_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sink_reset) begin
      state_q     <= IDLE;
      en_q        <= '0;
      active_q    <= '0;
      done_seen_q <= '0;
      start_q     <= '0;
      run_q       <= '0;
      fin_q       <= 1'b0;
      tmo_q       <= 1'b0;
      cycles_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      active_q    <= active_d;
      done_seen_q <= done_seen_d;
      start_q     <= start_d;
      run_q       <= run_d;
      fin_q       <= fin_d;
      tmo_q       <= tmo_d;
      cycles_q    <= cycles_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ctrl.data_out_control = rdata_q;
  assign core_start            = start_q;
  assign core_run              = run_q;
  assign irq                   = fin_q;

endmodule

// File: tb/tb_core_launch_controller.sv
// tb/tb_core_launch_controller.sv - scoreboard bench for core_launch_controller
module tb_core_launch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        wr, rd;
  logic [3:0]  done;
  logic [3:0]  start0, run0, start1, run1;
  logic        irq0, irq1;
  logic        rd_pend = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] exp;
    int          dut;
    string       name;
  } rd_item_t;

  rd_item_t   rdq[$];
  logic [3:0] stq[$];
  rd_item_t   mon_e;

  always #5 clk = ~clk;

  core_launch_controller_if #(.WIDTH(32)) if0 ();
  core_launch_controller_if #(.WIDTH(32)) if1 ();

  assign if0.address_control = addr;
  assign if0.data_in_control = wdata;
  assign if0.write_control   = wr;
  assign if0.read_control    = rd;
  assign if1.address_control = addr;
  assign if1.data_in_control = wdata;
  assign if1.write_control   = wr;
  assign if1.read_control    = rd;

  core_launch_controller #(.CORES(4), .WIDTH(32), .TIMEOUT(0)) dut (
    .clk(clk), .reset_sink_reset(rst), .ctrl(if0), .core_done(done),
    .core_start(start0), .core_run(run0), .irq(irq0)
  );

  core_launch_controller #(.CORES(4), .WIDTH(32), .TIMEOUT(100)) dut_t (
    .clk(clk), .reset_sink_reset(rst), .ctrl(if1), .core_done(done),
    .core_start(start1), .core_run(run1), .irq(irq1)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [31:0] e, input int d, input string n);
    rd_item_t it;
    it.exp = e; it.dut = d; it.name = n;
    rdq.push_back(it);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  always @(posedge clk) rd_pend <= rd;

  // Monitor: pops read expectations when read data is presented and
  // matches every core_start pulse of the main instance against the queue.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rdq.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got %0h expected no read", if0.data_out_control);
      end else begin
        mon_e = rdq.pop_front();
        chk(mon_e.name, (mon_e.dut == 0) ? if0.data_out_control : if1.data_out_control, mon_e.exp);
      end
    end
    if (start0 !== 4'b0000) begin
      if (stq.size() == 0) begin
        n_total++;
        $display("FAIL start_unexpected: got %0h expected 0", start0);
      end else begin
        chk("start_pulse", 32'(start0), 32'(stq.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0; done = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_outs", {if0.data_out_control[3:0], start0, run0, 3'b0, irq0}, 32'h0);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) rd_reg(3'(a), 32'h0, 0, "rst_reg");

    // Run 1: cores 0..2 enabled, core 3 holds done high while disabled.
    wr_reg(3'd2, 32'h1); wr_reg(3'd3, 32'h1); wr_reg(3'd4, 32'h1); wr_reg(3'd5, 32'h0);
    rd_reg(3'd3, 32'h1, 0, "en1_readback");
    stq.push_back(4'b0111);
    wr_reg(3'd0, 32'h1);
    @(negedge clk);
    chk("launch_start", 32'(start0), 32'h7);
    chk("launch_run", 32'(run0), 32'h0);
    tick();
    for (int k = 1; k <= 40; k++) begin
      done = {1'b1, k == 40, k == 25, k == 10};
      wr   = (k == 20);
      addr = 3'd5; wdata = 32'h1;
      @(negedge clk);
      if (k == 1) begin
        chk("run_mask", 32'(run0), 32'h7);
        chk("run_irq", 32'(irq0), 32'h0);
      end
      tick();
    end
    done = '0; wr = 1'b0;
    @(negedge clk);
    chk("fin_run", 32'(run0), 32'h0);
    chk("fin_irq", 32'(irq0), 32'h1);
    rd_reg(3'd0, 32'h1, 0, "busy_finish");
    rd_reg(3'd0, 32'h0, 0, "busy_idle");
    rd_reg(3'd6, 32'd40, 0, "cycles_40");
    rd_reg(3'd7, 32'h7, 0, "done_mask");
    rd_reg(3'd5, 32'h1, 0, "en3_midrun_write");

    // STATUS: writing 1 has no effect, writing 0 clears.
    wr_reg(3'd1, 32'h1);
    rd_reg(3'd1, 32'h1, 0, "status_w1_noop");
    wr_reg(3'd1, 32'h0);
    @(negedge clk);
    chk("irq_cleared", 32'(irq0), 32'h0);

    // Zero-mask run with a clear write on the finish-set edge.
    wr_reg(3'd2, 32'h0); wr_reg(3'd3, 32'h0); wr_reg(3'd4, 32'h0); wr_reg(3'd5, 32'h0);
    wr_reg(3'd0, 32'h1);
    @(negedge clk);
    chk("zero_no_start", 32'(start0), 32'h0);
    chk("zero_irq_n1", 32'(irq0), 32'h0);
    wr_reg(3'd1, 32'h0);
    @(negedge clk);
    chk("zero_irq_n2", 32'(irq0), 32'h1);
    rd_reg(3'd6, 32'h0, 0, "zero_cycles");
    rd_reg(3'd1, 32'h1, 0, "set_beats_clear");
    rd_reg(3'd7, 32'h0, 0, "zero_done");

    // Watchdog run on dut_t: core 1 never done; main instance runs alongside.
    wr_reg(3'd2, 32'h1); wr_reg(3'd3, 32'h1);
    stq.push_back(4'b0011);
    wr_reg(3'd0, 32'h1);
    @(negedge clk);
    chk("t_launch_start", 32'(start1), 32'h3);
    tick();
    for (int k = 1; k <= 100; k++) begin
      done = (k == 3) ? 4'b0001 : 4'b0000;
      wr   = (k == 50);
      addr = 3'd0; wdata = 32'h1;
      @(negedge clk);
      if (k == 1) begin
        chk("irq_kept_new_run", 32'(irq0), 32'h1);
        chk("t_run_mask", 32'(run1), 32'h3);
      end
      tick();
    end
    done = '0; wr = 1'b0;
    @(negedge clk);
    chk("t_run_drop", 32'(run1), 32'h0);
    chk("t_irq", 32'(irq1), 32'h1);
    chk("main_still_run", 32'(run0), 32'h3);
    rd_reg(3'd1, 32'h3, 1, "t_status");
    rd_reg(3'd0, 32'h0, 1, "t_busy");
    rd_reg(3'd6, 32'd100, 1, "t_cycles");
    rd_reg(3'd7, 32'h1, 1, "t_done");
    rd_reg(3'd0, 32'h1, 0, "main_busy");

    // Reset mid-run after an ignored second start.
    rst = 1'b1; tick(); rst = 1'b0;
    wr_reg(3'd2, 32'h1);
    stq.push_back(4'b0001);
    wr_reg(3'd0, 32'h1);
    tick();
    for (int k = 1; k <= 5; k++) begin
      wr   = (k == 2);
      addr = 3'd0; wdata = 32'h1;
      rst  = (k == 5);
      tick();
    end
    wr = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {if0.data_out_control[3:0], start0, run0, 3'b0, irq0}, 32'h0);
    for (int a = 0; a < 8; a++) rd_reg(3'(a), 32'h0, 0, "rst_mid_reg");
    for (int k = 0; k < 4; k++) tick();
    chk("start_queue_empty", 32'(stq.size()), 32'h0);
    chk("read_queue_empty", 32'(rdq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
